// File: rtl/reg_bank_sequencer_if.sv
// Request/result handshake bundle between instruction control and reg_bank_sequencer.
//
// Signals:
//   op_valid / op_ready        request handshake; transfer when both high on a rising edge
//   op_a, op_b [DATA_W]        operands, sampled on request transfer
//   op_code [OP_W]             ALU opcode, sampled on request transfer
//   res_valid / res_ready      result handshake; transfer when both high on a rising edge
//   res_data [DATA_W]          result, held while res_valid
//
// Modports:
//   master  instruction control side (drives the request, consumes the result)
//   slave   sequencer side
interface reg_bank_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 3
);
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [OP_W-1:0]   op_code;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        output op_valid, op_a, op_b, op_code, res_ready,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_a, op_b, op_code, res_ready,
        output op_ready, res_valid, res_data
    );
endinterface

// File: rtl/reg_bank_sequencer.sv
// Control-side sequencer for a 3-register operand/result bank (reg0 = data1, reg1 = data2,
// reg2 = result). A request (A, B, opcode) is written into the bank, the operands are read out
// to the ALU, the result is allowed ALU_LAT cycles to land in reg2, then reg2 is read back and
// returned over the result handshake.
//
// Ports:
//   seq_clk            clock, rising edge
//   seq_rst_n          asynchronous active-low reset
//   req                request/result handshake bundle (slave side)
//   alu_op             opcode to the ALU, held from one accept to the next
//   bank_rst           one-cycle synchronous clear to the bank after reset release
//   bank_data          bank data input
//   bank_selector      bank selector
//   bank_write_enable  bank write enable
//   bank_read_enable   bank read enable
//   bank_rd_data       bank second read port
//   res_zero           result-is-zero flag (only with REG_BANK_SEQ_ZERO_FLAG_EN defined)
//   busy               high in every state except idle
//
// Optional feature macro: REG_BANK_SEQ_ZERO_FLAG_EN adds the res_zero output.
module reg_bank_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned ALU_LAT = 1  // 1..15
) (
    input  logic                seq_clk,
    input  logic                seq_rst_n,
    reg_bank_sequencer_if.slave req,
    output logic [OP_W-1:0]     alu_op,
    output logic                bank_rst,
    output logic [DATA_W-1:0]   bank_data,
    output logic                bank_selector,
    output logic                bank_write_enable,
    output logic                bank_read_enable,
    input  logic [DATA_W-1:0]   bank_rd_data,
`ifdef REG_BANK_SEQ_ZERO_FLAG_EN
    output logic                res_zero,
`endif
    output logic                busy
);

    typedef enum logic [3:0] {
        StInit,
        StIdle,
        StWrA,
        StWrB,
        StRdOp,
        StAlu,
        StRdRes,
        StCap,
        StDone
    } state_e;

    localparam logic [3:0] AluLoad = 4'(ALU_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] b_q;
    logic              op_ready_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic              accept;

    logic              sel_d;
    logic              we_d;
    logic              re_d;
    logic [DATA_W-1:0] data_d;

    assign req.op_ready  = op_ready_q;
    assign req.res_valid = res_valid_q;
    assign req.res_data  = res_data_q;

    assign accept = (state_q == StIdle) && req.op_valid && op_ready_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StInit:  if (bank_rst) state_d = StIdle;  // stay until the clear pulse has gone out
            StIdle:  if (accept) state_d = StWrA;
            StWrA:   state_d = StWrB;
            StWrB:   state_d = StRdOp;
            StRdOp: begin
                state_d = StAlu;
                cnt_d   = AluLoad;
            end
            StAlu: begin
                if (cnt_q == 4'd0) state_d = StRdRes;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StRdRes: state_d = StCap;
            StCap:   state_d = StDone;
            StDone:  if (req.res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bank strobes are registered from the next state so they line up with the state itself.
    always_comb begin
        sel_d  = 1'b0;
        we_d   = 1'b0;
        re_d   = 1'b0;
        data_d = '0;
        case (state_d)
            StWrA: begin
                // Only entered on accept, so A goes straight from the request into bank_data;
                // the bank_data register is A's holding register.
                we_d   = 1'b1;
                data_d = req.op_a;
            end
            StWrB: begin
                sel_d  = 1'b1;
                we_d   = 1'b1;
                data_d = b_q;
            end
            StRdOp: re_d = 1'b1;
            StRdRes: begin
                sel_d = 1'b1;
                re_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge seq_clk or negedge seq_rst_n) begin
        if (!seq_rst_n) begin
            state_q           <= StInit;
            cnt_q             <= 4'd0;
            b_q               <= '0;
            op_ready_q        <= 1'b0;
            res_valid_q       <= 1'b0;
            res_data_q        <= '0;
            alu_op            <= '0;
            bank_rst          <= 1'b0;
            bank_data         <= '0;
            bank_selector     <= 1'b0;
            bank_write_enable <= 1'b0;
            bank_read_enable  <= 1'b0;
            busy              <= 1'b0;
`ifdef REG_BANK_SEQ_ZERO_FLAG_EN
            res_zero          <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            op_ready_q        <= (state_d == StIdle);
            busy              <= (state_d != StIdle);
            bank_rst          <= (state_d == StInit);
            bank_selector     <= sel_d;
            bank_write_enable <= we_d;
            bank_read_enable  <= re_d;
            bank_data         <= data_d;
            res_valid_q       <= (state_d == StDone);
            if (accept) begin
                b_q    <= req.op_b;
                alu_op <= req.op_code;
            end
            if (state_q == StCap) begin
                res_data_q <= bank_rd_data;
            end
`ifdef REG_BANK_SEQ_ZERO_FLAG_EN
            if (state_q == StCap) begin
                res_zero <= (bank_rd_data == '0);
            end else if (state_d != StDone) begin
                res_zero <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Self-checking bench for reg_bank_sequencer: a behavioural bank + ALU model answers the
// sequencer's strobes, expected results are queued at issue time and popped by a monitor
// whenever a result handshake completes.
module tb_reg_bank_sequencer;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned ALU_LAT = 1;

    logic              seq_clk = 1'b0;
    logic              seq_rst_n = 1'b0;
    logic [OP_W-1:0]   alu_op;
    logic              bank_rst;
    logic [DATA_W-1:0] bank_data;
    logic              bank_selector;
    logic              bank_write_enable;
    logic              bank_read_enable;
    logic [DATA_W-1:0] bank_rd_data = '0;
    logic              busy;
`ifdef REG_BANK_SEQ_ZERO_FLAG_EN
    logic              res_zero;
`endif

    reg_bank_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    reg_bank_sequencer #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .seq_clk          (seq_clk),
        .seq_rst_n        (seq_rst_n),
        .req              (bus),
        .alu_op           (alu_op),
        .bank_rst         (bank_rst),
        .bank_data        (bank_data),
        .bank_selector    (bank_selector),
        .bank_write_enable(bank_write_enable),
        .bank_read_enable (bank_read_enable),
        .bank_rd_data     (bank_rd_data),
`ifdef REG_BANK_SEQ_ZERO_FLAG_EN
        .res_zero         (res_zero),
`endif
        .busy             (busy)
    );

    always #5 seq_clk = ~seq_clk;

    int cyc = 0;
    always @(posedge seq_clk) cyc++;

    // Bank + ALU model
    logic [7:0] reg0 = '0;
    logic [7:0] reg1 = '0;
    logic [7:0] reg2 = '0;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always @(posedge seq_clk) begin
        if (bank_rst) begin
            reg0         <= '0;
            reg1         <= '0;
            reg2         <= '0;
            bank_rd_data <= '0;
        end else begin
            if (bank_write_enable) begin
                if (bank_selector) reg1 <= bank_data;
                else               reg0 <= bank_data;
            end
            if (bank_read_enable && !bank_selector) reg2 <= alu(reg0, reg1, alu_op);
            if (bank_read_enable && bank_selector)  bank_rd_data <= reg2;
        end
    end

    // Checking
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endfunction

    logic [25:0] outs;
    assign outs = {bus.op_ready, alu_op, bank_rst, bank_data, bank_selector, bank_write_enable,
                   bank_read_enable, bus.res_valid, bus.res_data, busy};

    logic [7:0] exp_q[$];
    int         hs_cyc = 0;

    // Scoreboard monitor: one pop per completed result handshake
    always @(negedge seq_clk) begin
        if (seq_rst_n && bus.res_valid && bus.res_ready) begin
            hs_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL res_unexpected: got %0h want none", bus.res_data);
            end else begin
                check("res_data", 32'(bus.res_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge seq_clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] exp, output int acc);
        int w = 0;
        acc = -1;
        while (!bus.op_ready && w < 100) begin
            tick();
            w++;
        end
        if (!bus.op_ready) begin
            n_checks++;
            $display("FAIL issue_timeout: op_ready got 0 want 1");
            return;
        end
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_code  = op;
        exp_q.push_back(exp);
        tick();
        acc = cyc;
        // Scramble inputs after accept; the operation in flight must not see them
        bus.op_valid = 1'b0;
        bus.op_a     = ~a;
        bus.op_b     = ~b;
        bus.op_code  = ~op;
    endtask

    task automatic wait_valid(input string name, input int acc, input int want_lat);
        int w = 0;
        while (!bus.res_valid && w < 50) begin
            tick();
            w++;
        end
        check(name, 32'(cyc - acc), 32'(want_lat));
    endtask

    // Expected {we, re, sel, data} k cycles after the accept of A=0x12, B=0x34
    function automatic logic [10:0] trace_exp(input int k);
        if (k == 0)                      return {3'b100, 8'h12};
        if (k == 1)                      return {3'b101, 8'h34};
        if (k == 2)                      return {3'b010, 8'h00};
        if (k == 3 + int'(ALU_LAT))      return {3'b011, 8'h00};
        return 11'd0;
    endfunction

    initial begin
        int acc;
        int acc2;
        int good;

        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_code   = '0;
        bus.res_ready = 1'b0;
        seq_rst_n     = 1'b0;

        // Reset
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outs", 32'(outs), 32'd0);
        end
        seq_rst_n = 1'b1;
        tick();
        check("init_bank_rst", {29'd0, bank_rst, busy, bus.op_ready}, 32'b110);
        tick();
        check("idle_ready", {29'd0, bank_rst, busy, bus.op_ready}, 32'b001);

        // Single add with strobe trace and latency
        bus.res_ready = 1'b1;
        issue(8'h12, 8'h34, 3'd0, 8'h46, acc);
        for (int k = 0; k < 4 + int'(ALU_LAT); k++) begin
            check("strobe_trace",
                  {21'd0, bank_write_enable, bank_read_enable, bank_selector, bank_data},
                  {21'd0, trace_exp(k)});
            tick();
        end
        wait_valid("add_latency", acc, 5 + int'(ALU_LAT));
        tick();
        check("valid_one_cycle", {31'd0, bus.res_valid}, 32'd0);

        // Subtract: alu_op must hold the accepted opcode despite scrambled op_code
        issue(8'h10, 8'h01, 3'd1, 8'h0F, acc);
        wait_valid("sub_latency", acc, 5 + int'(ALU_LAT));
        check("alu_op_sub", 32'(alu_op), 32'd1);
        tick();

        // Backpressure, with a stray request held during the window
        bus.res_ready = 1'b0;
        issue(8'hF0, 8'h0F, 3'd0, 8'hFF, acc);
        bus.op_valid = 1'b1;
        bus.op_a     = 8'hAA;
        bus.op_b     = 8'h55;
        bus.op_code  = 3'd5;
        wait_valid("bp_latency", acc, 5 + int'(ALU_LAT));
        good = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.res_valid && bus.res_data == 8'hFF && !bus.op_ready) good++;
            tick();
        end
        check("bp_hold", 32'(good), 32'd10);
        bus.op_valid = 1'b0;
        check("bp_alu_op", 32'(alu_op), 32'd0);
        bus.res_ready = 1'b1;
        tick();
        check("bp_release", {30'd0, bus.res_valid, bus.op_ready}, 32'b01);

        // Back-to-back
        issue(8'h01, 8'h02, 3'd0, 8'h03, acc);
        issue(8'h80, 8'h80, 3'd0, 8'h00, acc2);
        check("b2b_accept", 32'(acc2), 32'(hs_cyc + 1));
        check("b2b_throughput", 32'(acc2 - acc), 32'(7 + int'(ALU_LAT)));
        wait_valid("b2b_latency", acc2, 5 + int'(ALU_LAT));
        tick();

        // Reset in the ALU wait state
        issue(8'h11, 8'h22, 3'd0, 8'h33, acc);
        tick();
        tick();
        tick();
        #2;
        seq_rst_n = 1'b0;
        #1;
        check("midop_reset_outs", 32'(outs), 32'd0);
        exp_q.delete();
        good = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.res_valid) good++;
        end
        check("midop_no_valid", 32'(good), 32'd0);
        seq_rst_n = 1'b1;
        issue(8'h21, 8'h01, 3'd0, 8'h22, acc);
        wait_valid("post_reset_latency", acc, 5 + int'(ALU_LAT));
        tick();

        // Zero result (8-bit wrap)
        issue(8'h05, 8'hFB, 3'd0, 8'h00, acc);
        wait_valid("zero_latency", acc, 5 + int'(ALU_LAT));
`ifdef REG_BANK_SEQ_ZERO_FLAG_EN
        check("res_zero_set", {31'd0, res_zero}, 32'd1);
`endif
        tick();
`ifdef REG_BANK_SEQ_ZERO_FLAG_EN
        check("res_zero_clear", {31'd0, res_zero}, 32'd0);
`endif

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_bank_sequencer.md
Name: reg_bank_sequencer

Overview:
- Control-side counterpart of the 3-register operand/result bank (reg0 = data1, reg1 = data2, reg2 = result).
- Accepts an operation request (A, B, opcode) over a valid/ready handshake and sequences the bank's selector, write-enable and read-enable lines: write A, write B, read operands to the ALU, let the ALU result land in reg2, then read reg2 back.
- Returns the result over a second valid/ready handshake.
- Sits between instruction control and the register bank/ALU pair.

Parameters:
- DATA_W, 8, operand/result width.
- OP_W, 3, ALU opcode width.
- ALU_LAT, 1, cycles spent in S_ALU waiting for the result to reach reg2; legal range 1..15.

Ports:
- seq_clk  in  1  clock, all logic on rising edge.
- seq_rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  request valid.
- op_ready  out  1  request accepted when op_valid && op_ready on a rising edge.
- op_a  in  DATA_W  operand A, captured on accept.
- op_b  in  DATA_W  operand B, captured on accept.
- op_code  in  OP_W  ALU opcode, captured on accept.
- alu_op  out  OP_W  registered opcode to the ALU, held stable from accept until the next accept.
- bank_rst  out  1  synchronous active-high clear to the bank.
- bank_data  out  DATA_W  drives the bank's data input.
- bank_selector  out  1  bank selector.
- bank_write_enable  out  1  bank write enable.
- bank_read_enable  out  1  bank read enable.
- bank_rd_data  in  DATA_W  from the bank's second output port.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_data  out  DATA_W  result, held while res_valid.
- busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset (seq_rst_n low, asynchronous):
  - State goes to S_INIT.
  - Every output is 0: op_ready, alu_op, bank_*, res_valid, res_data, busy.
  - The ALU wait counter is 0.
  - Reset mid-operation abandons the operation immediately; no result is produced.
- All bank_* outputs are registered Moore outputs. Any bank line not listed for a state is 0.
- State sequence:
  - S_INIT: bank_rst=1 for exactly one cycle after reset release; busy=1 -> S_IDLE.
  - S_IDLE: op_ready=1, busy=0. On accept: capture op_a/op_b into internal registers, load op_code into alu_op -> S_WR_A.
  - S_WR_A: bank_selector=0, bank_write_enable=1, bank_data=A -> S_WR_B.
  - S_WR_B: bank_selector=1, bank_write_enable=1, bank_data=B -> S_RD_OP.
  - S_RD_OP: bank_selector=0, bank_read_enable=1; operands reach the ALU on the following edge -> S_ALU.
  - S_ALU: all bank strobes 0; stay ALU_LAT cycles (4-bit down-counter loaded with ALU_LAT-1 on entry) -> S_RD_RES.
  - S_RD_RES: bank_selector=1, bank_read_enable=1 -> S_CAP.
  - S_CAP: res_data <= bank_rd_data, res_valid <= 1 -> S_DONE.
  - S_DONE: hold res_valid and res_data until res_ready, then res_valid=0 -> S_IDLE.
- Latency:
  - Accept edge to res_valid high = 5 + ALU_LAT cycles (6 at default).
  - Back-to-back throughput is one operation per 7 + ALU_LAT cycles.
- Boundary conditions:
  - op_ready=1 only in S_IDLE; op_valid is ignored in every other state.
  - res_ready asserted outside S_DONE is ignored.
  - res_ready already high on entry to S_DONE: res_valid lasts exactly one cycle.
  - Changes to op_a/op_b/op_code after accept have no effect on the operation in flight.
  - No arithmetic is done in this block; data passes through unmodified at DATA_W bits.
- Illegal state encodings recover to S_IDLE with all strobes 0.

Optional Feature:
- Macro: REG_BANK_SEQ_ZERO_FLAG_EN.
- Defined:
  - Adds output res_zero (1 bit).
  - res_zero is set in S_CAP to (bank_rd_data == 0) and held alongside res_data.
  - res_zero is 0 on reset and cleared when leaving S_DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold seq_rst_n low 3 cycles, release -> all outputs 0 during reset; bank_rst=1 for exactly one cycle; op_ready=1 on the next cycle.
- Single add: bench ALU models add on op_code=0; send A=0x12, B=0x34 with res_ready=1 -> res_valid rises 6 cycles after accept with res_data=0x46. Bank strobe trace must be WR(sel0,0x12), WR(sel1,0x34), RD(sel0), idle, RD(sel1).
- Backpressure: A=0xF0, B=0x0F, op_code=0, res_ready=0 for 10 cycles -> res_valid and res_data=0xFF stay stable; op_ready=0 throughout; a second op_valid during this window is not accepted.
- Back-to-back: two requests, (1,2) then (0x80,0x80) -> results 0x03 then 0x00 (8-bit wrap); second accept occurs exactly one cycle after the first result handshake.
- Reset mid-operation: assert seq_rst_n low during S_ALU -> outputs 0 asynchronously (same cycle); no res_valid; the next request completes normally.
- ALU_LAT=3 build with REG_BANK_SEQ_ZERO_FLAG_EN: A=0x05, B=0xFB add -> res_valid 8 cycles after accept, res_data=0x00, res_zero=1.
